layer_sequencer: RTL and testbench

//  Runs a NUM_LAYERS-deep fully-connected net on one physical `layer` instance by time-multiplexing it.

---
 rtl/layer_pkg.sv | 18 +
 rtl/layer_sequencer_frame_timer.sv | 33 +++
 rtl/layer_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_layer_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// Shared types and helpers for the time-multiplexed layer sequencer.
package layer_pkg;

   localparam int SIZE_DEF  = 3;
   localparam int DEPTH_DEF = 8;

   typedef enum logic [2:0] {IDLE, LOAD, WFETCH, RUN, DRAIN, DONE} seq_state_t;

   typedef logic [SIZE_DEF-1:0][SIZE_DEF-1:0][DEPTH_DEF-1:0] weight_mat_t;

   localparam int SLOT_W = $clog2(SIZE_DEF + 1);

   // Slot counter width for a frame of size+1 slots.
   function automatic int slot_width(input int size);
      return (size < 1) ? 1 : $clog2(size + 1);
   endfunction

endpackage

// File: rtl/layer_sequencer_frame_timer.sv
// Frame slot counter (0..SIZE) with flags for the last payload slot and the STORE slot.
module frame_timer
   import layer_pkg::*;
#(
   parameter int SIZE = 3,
   parameter int SW   = slot_width(SIZE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [SW-1:0] slot,
   output logic          payload_last,
   output logic          slot_last
);

   logic [SW-1:0] slot_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_reg <= '0;
      end else if (clr) begin
         slot_reg <= '0;
      end else if (en) begin
         slot_reg <= (slot_reg == SW'(SIZE)) ? '0 : slot_reg + SW'(1);
      end
   end

   assign slot         = slot_reg;
   assign payload_last = (slot_reg == SW'(SIZE - 1));
   assign slot_last    = (slot_reg == SW'(SIZE));

endmodule

// File: rtl/layer_sequencer.sv
// Time-multiplexes one fully-connected layer over NUM_LAYERS logical layers:
// buffers inputs, fetches per-layer weights, drives layer frames and drains results.
module layer_sequencer
   import layer_pkg::*;
#(
   parameter int SIZE       = 3,
   parameter int DEPTH      = 8,
   parameter int NUM_LAYERS = 4,
   parameter int LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DEPTH-1:0]            in_data,
   output logic                        w_rd_en,
   output logic [LAYER_W-1:0]          w_rd_addr,
   input  logic [SIZE*SIZE*DEPTH-1:0]  w_rd_data,
   output logic                        layer_rst,
   output logic                        input_select,
   output logic [DEPTH-1:0]            x_input,
   output logic [SIZE*SIZE*DEPTH-1:0]  w,
   input  logic [DEPTH-1:0]            y,
   output logic                        out_valid,
   output logic [DEPTH-1:0]            out_data
);

   localparam int SW    = slot_width(SIZE);
   localparam int MAT_W = SIZE * SIZE * DEPTH;
   localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

   seq_state_t          state_reg, state_next;
   logic                wf_phase_reg, wf_phase_next;
   logic [LAYER_W-1:0]  layer_reg, layer_next;
   logic [SW-1:0]       load_cnt_reg, load_cnt_next;
   logic [MAT_W-1:0]    w_reg;
   logic                w_load;
   logic                beat;
   logic [SIZE-1:0][DEPTH-1:0] buffer;
   logic [DEPTH-1:0]    x_sel;

   logic [SW-1:0]       slot;
   logic                payload_last, slot_last;
   logic                timer_en;

   assign beat     = (state_reg == LOAD) && in_valid;
   assign timer_en = (state_reg == RUN) || (state_reg == DRAIN);

   frame_timer #(.SIZE(SIZE), .SW(SW)) u_frame_timer (
      .clk          (clk),
      .rst          (rst),
      .clr          (!timer_en),
      .en           (timer_en),
      .slot         (slot),
      .payload_last (payload_last),
      .slot_last    (slot_last)
   );

   genvar gi;
   generate
      for (gi = 0; gi < SIZE; gi++) begin : g_buf
         logic [DEPTH-1:0] word_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               word_reg <= '0;
            end else if (beat && (load_cnt_reg == SW'(gi))) begin
               word_reg <= in_data;
            end
         end
         assign buffer[gi] = word_reg;
      end
   endgenerate

   always_comb begin
      x_sel = '0;
      for (int i = 0; i < SIZE; i++) begin
         if (slot == SW'(i)) begin
            x_sel = buffer[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         wf_phase_reg <= 1'b0;
         layer_reg    <= '0;
         load_cnt_reg <= '0;
         w_reg        <= '0;
      end else begin
         state_reg    <= state_next;
         wf_phase_reg <= wf_phase_next;
         layer_reg    <= layer_next;
         load_cnt_reg <= load_cnt_next;
         if (w_load) begin
            w_reg <= w_rd_data;
         end
      end
   end

   assign w = w_reg;

   always_comb begin
      state_next    = state_reg;
      wf_phase_next = wf_phase_reg;
      layer_next    = layer_reg;
      load_cnt_next = load_cnt_reg;
      busy          = 1'b1;
      done          = 1'b0;
      in_ready      = 1'b0;
      w_rd_en       = 1'b0;
      w_rd_addr     = '0;
      layer_rst     = 1'b1;
      input_select  = 1'b1;
      x_input       = '0;
      out_valid     = 1'b0;
      out_data      = '0;
      w_load        = 1'b0;

      case (state_reg)
         IDLE: begin
            busy          = 1'b0;
            load_cnt_next = '0;
            layer_next    = '0;
            if (start) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (load_cnt_reg == SW'(SIZE - 1)) begin
                  state_next    = WFETCH;
                  wf_phase_next = 1'b0;
               end else begin
                  load_cnt_next = load_cnt_reg + SW'(1);
               end
            end
         end
         WFETCH: begin
            if (!wf_phase_reg) begin
               w_rd_en       = 1'b1;
               wf_phase_next = 1'b1;
            end else begin
               w_load        = 1'b1;
               wf_phase_next = 1'b0;
               layer_next    = '0;
               state_next    = RUN;
            end
         end
         RUN: begin
            layer_rst = 1'b0;
            if (layer_reg == '0) begin
               input_select = 1'b1;
               if (!slot_last) begin
                  x_input = x_sel;
               end
            end else begin
               input_select = 1'b0;
            end
            // Prefetch the next layer's weights so they land exactly at the frame boundary.
            if (payload_last && (layer_reg != LAST_LAYER)) begin
               w_rd_en   = 1'b1;
               w_rd_addr = layer_reg + LAYER_W'(1);
            end
            if (slot_last) begin
               if (layer_reg != LAST_LAYER) begin
                  w_load     = 1'b1;
                  layer_next = layer_reg + LAYER_W'(1);
               end else begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            layer_rst    = 1'b0;
            input_select = 1'b0;
            out_valid    = 1'b1;
            out_data     = y;
            if (payload_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: behavioural layer + weight RAM, matrix-arithmetic reference.
module tb_layer_sequencer;

   localparam int SIZE  = 3;
   localparam int DEPTH = 8;
   localparam int NL    = 2;
   localparam int LW    = 1;
   localparam int MAT_W = SIZE * SIZE * DEPTH;
   localparam int FRAME = SIZE + 1;

   logic             clk = 1'b0;
   logic             rst, start, busy, done, in_valid, in_ready;
   logic [DEPTH-1:0] in_data;
   logic             w_rd_en;
   logic [LW-1:0]    w_rd_addr;
   logic [MAT_W-1:0] w_rd_data;
   logic             layer_rst, input_select;
   logic [DEPTH-1:0] x_input;
   logic [MAT_W-1:0] w;
   logic [DEPTH-1:0] y;
   logic             out_valid;
   logic [DEPTH-1:0] out_data;

   int checks   = 0;
   int failures = 0;

   logic [MAT_W-1:0] wmem [NL];
   logic [DEPTH-1:0] xin [SIZE];
   int               exp_y [SIZE];
   logic [31:0]      vpat;
   bit               hold_start;

   always #5 clk = ~clk;

   layer_sequencer #(.SIZE(SIZE), .DEPTH(DEPTH), .NUM_LAYERS(NL)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .w_rd_en      (w_rd_en),
      .w_rd_addr    (w_rd_addr),
      .w_rd_data    (w_rd_data),
      .layer_rst    (layer_rst),
      .input_select (input_select),
      .x_input      (x_input),
      .w            (w),
      .y            (y),
      .out_valid    (out_valid),
      .out_data     (out_data)
   );

   // Weight RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
   end

   // Behavioural layer: CLEAR/SHIFT capture x, STORE computes y = W*x (linear, mod 2^DEPTH).
   int               lslot = 0;
   logic [DEPTH-1:0] xcap [SIZE];
   logic [DEPTH-1:0] yvec [SIZE];

   function automatic logic [DEPTH-1:0] layer_dot(input int i);
      int acc = 0;
      for (int j = 0; j < SIZE; j++)
         acc += int'(w[(i*SIZE+j)*DEPTH +: DEPTH]) * int'(xcap[j]);
      return DEPTH'(acc);
   endfunction

   always @(posedge clk) begin
      if (layer_rst) begin
         lslot <= 0;
         for (int i = 0; i < SIZE; i++) begin
            xcap[i] <= '0;
            yvec[i] <= '0;
         end
      end else begin
         if (lslot < SIZE) xcap[lslot] <= input_select ? x_input : yvec[lslot];
         else for (int i = 0; i < SIZE; i++) yvec[i] <= layer_dot(i);
         lslot <= (lslot == SIZE) ? 0 : lslot + 1;
      end
   end

   assign y = (lslot < SIZE) ? yvec[lslot] : '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
         $error("check %s", tag);
      end
   endtask

   // Reference: the inference is NL successive matrix-vector products, each truncated to DEPTH bits.
   function automatic void ref_infer();
      int v [SIZE];
      int nv [SIZE];
      for (int i = 0; i < SIZE; i++) v[i] = int'(xin[i]);
      for (int l = 0; l < NL; l++) begin
         for (int i = 0; i < SIZE; i++) begin
            nv[i] = 0;
            for (int j = 0; j < SIZE; j++)
               nv[i] += int'(wmem[l][(i*SIZE+j)*DEPTH +: DEPTH]) * v[j];
            nv[i] = nv[i] % (1 << DEPTH);
         end
         v = nv;
      end
      for (int i = 0; i < SIZE; i++) exp_y[i] = v[i];
   endfunction

   function automatic logic [MAT_W-1:0] diag(input int k);
      logic [MAT_W-1:0] m = '0;
      for (int i = 0; i < SIZE; i++) m[(i*SIZE+i)*DEPTH +: DEPTH] = DEPTH'(k);
      return m;
   endfunction

   function automatic logic [MAT_W-1:0] rand_mat();
      logic [MAT_W-1:0] m;
      for (int i = 0; i < SIZE*SIZE; i++) m[i*DEPTH +: DEPTH] = DEPTH'($urandom_range(0, 255));
      return m;
   endfunction

   task automatic rand_inputs();
      for (int i = 0; i < SIZE; i++) xin[i] = DEPTH'($urandom_range(0, 255));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_w_rd_en"}, w_rd_en, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_layer_rst"}, layer_rst, 1);
      chk({tag, "_input_select"}, input_select, 1);
      chk({tag, "_x_input"}, x_input, 0);
      chk({tag, "_w"}, w, 0);
      chk({tag, "_out_data"}, out_data, 0);
   endtask

   // One full inference. c counts cycles after the last input beat (c=1 is the first cycle after it).
   task automatic run_inf(input string tag);
      int idx, cyc, n_out, first_out, n_done, done_c, bad_w;
      bit exp_rd;
      logic [MAT_W-1:0] w_prev;
      ref_infer();
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < SIZE && cyc < 64) begin
         chk({tag, "_load_ready"}, in_ready, 1);
         chk({tag, "_load_no_rd"}, w_rd_en, 0);
         in_valid = vpat[cyc % 32];
         in_data  = xin[idx];
         @(posedge clk); #1;
         if (in_valid) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      in_data  = '0;
      chk({tag, "_beats"}, idx, SIZE);
      n_out = 0; first_out = -1; n_done = 0; done_c = -1; bad_w = 0;
      w_prev = w;
      for (int c = 1; c <= 80; c++) begin
         if (c == 1) chk({tag, "_ready_drop"}, in_ready, 0);
         if (c == 2) chk({tag, "_lrst_hi"}, layer_rst, 1);
         if (c == 3) chk({tag, "_lrst_fall"}, layer_rst, 0);
         if (c >= 3 && c < 3 + SIZE) begin
            chk({tag, "_x_input"}, x_input, xin[c-3]);
            chk({tag, "_in_sel"}, input_select, 1);
         end
         exp_rd = (c == 1) ||
                  (c >= 3 && c < 3 + (NL-1)*FRAME && ((c-3) % FRAME) == SIZE-1);
         chk({tag, "_rd_en"}, w_rd_en, exp_rd);
         if (exp_rd) chk({tag, "_rd_addr"}, w_rd_addr, (c == 1) ? 0 : (c-3)/FRAME + 1);
         if (w !== w_prev) begin
            if (c < 3 || ((c-3) % FRAME) != 0) bad_w++;
            w_prev = w;
         end
         if (c >= 3 && c < 3 + NL*FRAME && ((c-3) % FRAME) == 0)
            chk({tag, "_w_frame"}, w, wmem[(c-3)/FRAME]);
         if (out_valid) begin
            if (n_out < SIZE) chk({tag, "_out_data"}, out_data, exp_y[n_out]);
            if (n_out == 0) first_out = c;
            n_out++;
         end
         if (done) begin
            n_done++;
            done_c = c;
         end
         if (done_c > 0 && c == done_c + 1) begin
            chk({tag, "_idle_busy"}, busy, 0);
            chk({tag, "_idle_ready"}, in_ready, 0);
            break;
         end
         @(posedge clk); #1;
      end
      chk({tag, "_n_out"}, n_out, SIZE);
      chk({tag, "_latency"}, first_out, 1 + 2 + NL*FRAME);
      chk({tag, "_n_done"}, n_done, 1);
      chk({tag, "_done_pos"}, done_c, first_out + SIZE);
      chk({tag, "_w_stable"}, bad_w, 0);
      $display("inference %s: y=%0d,%0d,%0d outs=%0d first_out_c=%0d done_c=%0d",
               tag, exp_y[0], exp_y[1], exp_y[2], n_out, first_out, done_c);
   endtask

   task automatic run_abort();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < SIZE; k++) begin
         in_valid = 1'b1;
         in_data  = xin[k];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (2 + FRAME + 1) @(posedge clk);
      #1;
      chk("abort_pre_layer1", input_select, 0);
      chk("abort_pre_run", layer_rst, 0);
      #1 rst = 1'b1;
      #1 chk_reset("abort");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_idle", busy, 0);
      $display("abort: reset applied in layer 1 slot 1");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      hold_start = 1'b0; vpat = '1;
      for (int l = 0; l < NL; l++) wmem[l] = '0;
      repeat (3) @(posedge clk);
      #1 chk_reset("por");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("por_idle", busy, 0);

      xin[0] = 8'd5; xin[1] = 8'd6; xin[2] = 8'd7;
      wmem[0] = diag(1); wmem[1] = diag(2);
      run_inf("ident");

      vpat = 32'b101001;
      rand_inputs();
      wmem[0] = rand_mat(); wmem[1] = rand_mat();
      run_inf("gaps");
      vpat = '1;

      rand_inputs();
      run_abort();
      rand_inputs();
      wmem[0] = rand_mat(); wmem[1] = rand_mat();
      run_inf("after_abort");

      hold_start = 1'b1;
      rand_inputs();
      run_inf("hold_a");
      rand_inputs();
      run_inf("hold_b");
      hold_start = 1'b0;
      start = 1'b0;

      for (int r = 0; r < 4; r++) begin
         rand_inputs();
         wmem[0] = rand_mat(); wmem[1] = rand_mat();
         vpat = $urandom | 32'h1;
         run_inf("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
